pipe_power_rate_ctrl: RTL and testbench
=======================================

Name: pipe_power_rate_ctrl

Overview:
MAC-side sequencer for the PIPE command/status handshakes. It owns the PowerDown, Rate and PclkChangeAck outputs toward the PHY and performs the reset-release wait on PhyStatus. It accepts one power-state or rate-change request at a time from the LTSSM, executes the PIPE handshake across all lanes, and reports completion or timeout.

Parameters:
pipe_num_of_lanes, 16, number of PIPE lanes; PhyStatus is collected per lane.
TIMEOUT_CYCLES, 65535, maximum PCLK cycles spent in any wait state before error.
PCLK_CHANGE_EN, 1, 1 = rate change uses the PclkChangeOk/PclkChangeAck handshake; 0 = skip it.

Ports:
PCLK  in  1  PIPE clock; the only clock.
Reset  in  1  asynchronous, active-low reset.
req_valid  in  1  request strobe from LTSSM.
req_ready  out  1  controller can accept a request.
req_type  in  1  0 = power-state change, 1 = rate change.
req_powerdown  in  4  target PowerDown encoding, used when req_type=0.
req_rate  in  4  target Rate encoding, used when req_type=1.
done  out  1  one-cycle pulse when a request completes successfully.
error  out  1  one-cycle pulse when a wait state times out.
busy  out  1  high from request acceptance until done or error.
phy_ready  out  1  high once the post-reset PhyStatus deassertion has been seen.
PowerDown  out  4*pipe_num_of_lanes  same 4-bit value replicated per lane.
Rate  out  4  current rate.
PclkChangeAck  out  1  rate-change acknowledge to PHY.
PclkChangeOk  in  1  PHY ready for PCLK change.
PhyStatus  in  pipe_num_of_lanes  per-lane PHY status.

Behaviour:
- Reset asserted, asynchronous: state=RST_WAIT; PowerDown=4'b0010 (P1) on every lane; Rate=0; PclkChangeAck=0; req_ready=0; done=0; error=0; busy=0; phy_ready=0; timeout counter=0.
- RST_WAIT: go to IDLE once PhyStatus==0 on all lanes, then set phy_ready=1 permanently until the next reset. Timeout does not apply in this state.
- IDLE: req_ready=1. A request is accepted on req_valid&&req_ready in cycle N. The target is captured and req_ready drops in N+1. busy is high from N+1.
- Power request, target equals current PowerDown: done pulses in N+1, return to IDLE, no PHY change.
- Power request otherwise: PowerDown is updated in N+1, the per-lane sticky PhyStatus collector is cleared, state=PD_WAIT.
- PD_WAIT: the collector ORs in PhyStatus each cycle. When all bits are set, done pulses the next cycle and the state returns to IDLE.
- Rate request, target equals current Rate: done pulses in N+1 with no handshake.
- Rate request otherwise: Rate is updated in N+1. If PCLK_CHANGE_EN=1, state=RATE_WAIT_OK; else the collector is cleared and state=RATE_WAIT_STATUS.
- RATE_WAIT_OK: when PclkChangeOk==1, PclkChangeAck=1 in the next cycle, the collector is cleared, state=RATE_WAIT_STATUS. PhyStatus is ignored while in RATE_WAIT_OK.
- RATE_WAIT_STATUS: the collector ORs PhyStatus. When all lanes are set, PclkChangeAck=0 and done pulses in the same next cycle, then the state returns to IDLE.
- Timeout: a 16-bit-or-wider counter clears on entry to every wait state and increments each cycle in it. At TIMEOUT_CYCLES: error pulses, PclkChangeAck=0, state returns to IDLE. PowerDown/Rate keep their new value.
- done and error are never high together, and neither is high in the cycle req_ready rises.
- Reset mid-operation: immediate return to reset values, and any in-flight request is dropped without done or error.
- req_valid while busy is ignored, with no queueing.

Test Plan:
- Reset release: hold PhyStatus=all-1 for 10 cycles after Reset rises, then 0 -> phy_ready=1 and req_ready=1 in the cycle after PhyStatus=0; PowerDown=0x2222...; Rate=0.
- Power change P1->P0: req_powerdown=0, PhyStatus pulses on lanes 0-7 at cycle 5 and lanes 8-15 at cycle 9 -> PowerDown=0 in N+1, single done at cycle 10, busy low after.
- Rate change 0->2 with PCLK_CHANGE_EN=1: PclkChangeOk at cycle 4, all-lane PhyStatus at cycle 8 -> Rate=2 in N+1, PclkChangeAck high cycles 5-8, done at cycle 9.
- Same-value request: rate request with req_rate=0 while Rate=0 -> done in N+1, PclkChangeAck never asserts.
- Timeout with TIMEOUT_CYCLES=20: power change with lane 3 never pulsing PhyStatus -> error pulse 20 cycles after PD_WAIT entry, no done, req_ready=1 next cycle.
- Reset during RATE_WAIT_STATUS -> all outputs at reset values immediately, PclkChangeAck=0, no done or error.

Source files
------------

// File: rtl/pipe_power_rate_ctrl.sv
// Purpose: MAC-side PIPE sequencer for PowerDown / Rate changes and the post-reset PhyStatus wait.
// Latency: target driven 1 cycle after acceptance; done/error 1 cycle after the last PhyStatus or timeout.
// Backpressure: req_ready is high only in IDLE; req_valid while busy is dropped, with no queueing.
//
// Ports:
//   PCLK, Reset                 clock and asynchronous active-low reset
//   req_valid/req_ready         request handshake from the LTSSM
//   req_type                    0 = power-state change, 1 = rate change
//   req_powerdown, req_rate     requested PowerDown / Rate encodings
//   done, error                 one-cycle completion / timeout pulses
//   busy                        high from acceptance through the done/error cycle
//   phy_ready                   high once PhyStatus has deasserted after reset
//   PowerDown, Rate             PIPE outputs (PowerDown replicated per lane)
//   PclkChangeAck/PclkChangeOk  PCLK change handshake with the PHY
//   PhyStatus                   per-lane PHY status
module pipe_power_rate_ctrl #(
    parameter int pipe_num_of_lanes = 16,
    parameter int TIMEOUT_CYCLES    = 65535,
    parameter bit PCLK_CHANGE_EN    = 1'b1
) (
    input  logic                           PCLK,
    input  logic                           Reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_type,
    input  logic [3:0]                     req_powerdown,
    input  logic [3:0]                     req_rate,
    output logic                           done,
    output logic                           error,
    output logic                           busy,
    output logic                           phy_ready,
    output logic [4*pipe_num_of_lanes-1:0] PowerDown,
    output logic [3:0]                     Rate,
    output logic                           PclkChangeAck,
    input  logic                           PclkChangeOk,
    input  logic [pipe_num_of_lanes-1:0]   PhyStatus
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [3:0] PD_P1 = 4'b0010;

    // COMPLETE holds the done/error cycle so req_ready only rises afterwards.
    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        PD_WAIT,
        RATE_WAIT_OK,
        RATE_WAIT_STATUS,
        COMPLETE
    } state_t;

    state_t                         state_q, state_d;
    logic [3:0]                     pd_q, pd_d;
    logic [3:0]                     rate_q, rate_d;
    logic                           ack_q, ack_d;
    logic                           req_ready_q, req_ready_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic                           busy_q, busy_d;
    logic                           phy_ready_q, phy_ready_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [pipe_num_of_lanes-1:0]   coll_q, coll_d;

    logic [CNT_W-1:0]               cnt_inc;
    logic [pipe_num_of_lanes-1:0]   coll_or;
    logic                           timeout_hit;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == TIMEOUT_VAL);
    // Sticky collector including this cycle's PhyStatus, so the last
    // arriving lane completes the wait on the same edge it is sampled.
    assign coll_or     = coll_q | PhyStatus;

    always_comb begin
        state_d     = state_q;
        pd_d        = pd_q;
        rate_d      = rate_q;
        ack_d       = ack_q;
        req_ready_d = req_ready_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        busy_d      = busy_q;
        phy_ready_d = phy_ready_q;
        cnt_d       = cnt_q;
        coll_d      = coll_q;

        case (state_q)
            RST_WAIT: begin
                if (PhyStatus == '0) begin
                    state_d     = IDLE;
                    phy_ready_d = 1'b1;
                    req_ready_d = 1'b1;
                end
            end

            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    coll_d      = '0;
                    if (!req_type) begin
                        if (req_powerdown == pd_q) begin
                            done_d  = 1'b1;
                            state_d = COMPLETE;
                        end else begin
                            pd_d    = req_powerdown;
                            state_d = PD_WAIT;
                        end
                    end else begin
                        if (req_rate == rate_q) begin
                            done_d  = 1'b1;
                            state_d = COMPLETE;
                        end else begin
                            rate_d  = req_rate;
                            state_d = PCLK_CHANGE_EN ? RATE_WAIT_OK : RATE_WAIT_STATUS;
                        end
                    end
                end
            end

            PD_WAIT: begin
                coll_d = coll_or;
                if (&coll_or) begin
                    done_d  = 1'b1;
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = COMPLETE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // PhyStatus is deliberately not collected here; the status
            // wait starts fresh once the PHY has agreed to the PCLK change.
            RATE_WAIT_OK: begin
                if (PclkChangeOk) begin
                    ack_d   = 1'b1;
                    coll_d  = '0;
                    cnt_d   = '0;
                    state_d = RATE_WAIT_STATUS;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    ack_d   = 1'b0;
                    state_d = COMPLETE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RATE_WAIT_STATUS: begin
                coll_d = coll_or;
                if (&coll_or) begin
                    done_d  = 1'b1;
                    ack_d   = 1'b0;
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    ack_d   = 1'b0;
                    state_d = COMPLETE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            COMPLETE: begin
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RST_WAIT;
            pd_q        <= PD_P1;
            rate_q      <= 4'd0;
            ack_q       <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            phy_ready_q <= 1'b0;
            cnt_q       <= '0;
            coll_q      <= '0;
        end else begin
            state_q     <= state_d;
            pd_q        <= pd_d;
            rate_q      <= rate_d;
            ack_q       <= ack_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            phy_ready_q <= phy_ready_d;
            cnt_q       <= cnt_d;
            coll_q      <= coll_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign done          = done_q;
    assign error         = error_q;
    assign busy          = busy_q;
    assign phy_ready     = phy_ready_q;
    assign PowerDown     = {pipe_num_of_lanes{pd_q}};
    assign Rate          = rate_q;
    assign PclkChangeAck = ack_q;

endmodule

// File: tb/tb_pipe_power_rate_ctrl.sv
// Directed bench for pipe_power_rate_ctrl: 16 lanes, TIMEOUT_CYCLES=20, PCLK change handshake enabled.
// Inputs change 1 time unit after each rising PCLK edge; outputs are sampled at the same point.
// Cycle c below counts edges after the request was presented (c=1 is the first cycle after acceptance).
module tb_pipe_power_rate_ctrl;

    localparam int LANES = 16;
    localparam logic [63:0] PD_RST = {16{4'h2}};

    logic             PCLK;
    logic             Reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_type;
    logic [3:0]       req_powerdown;
    logic [3:0]       req_rate;
    logic             done;
    logic             error;
    logic             busy;
    logic             phy_ready;
    logic [63:0]      PowerDown;
    logic [3:0]       Rate;
    logic             PclkChangeAck;
    logic             PclkChangeOk;
    logic [LANES-1:0] PhyStatus;

    int checks = 0;
    int errors = 0;

    pipe_power_rate_ctrl #(
        .pipe_num_of_lanes(LANES),
        .TIMEOUT_CYCLES   (20),
        .PCLK_CHANGE_EN   (1'b1)
    ) dut (
        .PCLK          (PCLK),
        .Reset         (Reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_powerdown (req_powerdown),
        .req_rate      (req_rate),
        .done          (done),
        .error         (error),
        .busy          (busy),
        .phy_ready     (phy_ready),
        .PowerDown     (PowerDown),
        .Rate          (Rate),
        .PclkChangeAck (PclkChangeAck),
        .PclkChangeOk  (PclkChangeOk),
        .PhyStatus     (PhyStatus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; req_valid = 1'b0; req_type = 1'b0; req_powerdown = 4'h0;
        req_rate = 4'h0; PclkChangeOk = 1'b0; PhyStatus = '1;
        tick(); tick();
        checks++;
        if ({req_ready, busy, done, error, phy_ready, PclkChangeAck} !== 6'b0) begin
            errors++; $display("FAIL rst_ctrl got %b expected 000000", {req_ready, busy, done, error, phy_ready, PclkChangeAck});
        end
        checks++;
        if (PowerDown !== PD_RST || Rate !== 4'h0) begin
            errors++; $display("FAIL rst_pd_rate got %h/%h expected %h/0", PowerDown, Rate, PD_RST);
        end
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (phy_ready !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_hold got phy_ready=%b req_ready=%b expected 0/0", phy_ready, req_ready);
        end
        PhyStatus = '0;
        tick();
        checks++;
        if (phy_ready !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_release got phy_ready=%b req_ready=%b busy=%b expected 1/1/0", phy_ready, req_ready, busy);
        end
        checks++;
        if (PowerDown !== PD_RST || Rate !== 4'h0) begin
            errors++; $display("FAIL rst_release_pd got %h/%h expected %h/0", PowerDown, Rate, PD_RST);
        end
    endtask

    task automatic test_same_value();
        int ack_seen;
        ack_seen = 0;
        req_valid = 1'b1; req_type = 1'b1; req_rate = 4'h0;
        tick();
        req_valid = 1'b0;
        if (PclkChangeAck) ack_seen++;
        checks++;
        if ({done, busy, req_ready, error} !== 4'b1100) begin
            errors++; $display("FAIL same_c1 got done,busy,rdy,err=%b expected 1100", {done, busy, req_ready, error});
        end
        tick();
        if (PclkChangeAck) ack_seen++;
        checks++;
        if ({done, busy, req_ready} !== 3'b001 || Rate !== 4'h0) begin
            errors++; $display("FAIL same_c2 got done,busy,rdy=%b rate=%h expected 001 rate=0", {done, busy, req_ready}, Rate);
        end
        tick();
        if (PclkChangeAck) ack_seen++;
        checks++;
        if (ack_seen !== 0) begin
            errors++; $display("FAIL same_ack got %0d ack cycles expected 0", ack_seen);
        end
    endtask

    task automatic test_power_change();
        int done_cnt, done_at;
        done_cnt = 0; done_at = -1;
        req_valid = 1'b1; req_type = 1'b0; req_powerdown = 4'h0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (PowerDown !== 64'h0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL pd_c1 got pd=%h busy=%b rdy=%b expected 0/1/0", PowerDown, busy, req_ready);
        end
        for (int c = 1; c <= 11; c++) begin
            if (done) begin done_cnt++; done_at = c; end
            PhyStatus = (c == 5) ? 16'h00FF : (c == 9) ? 16'hFF00 : 16'h0000;
            if (c < 11) tick();
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 10) begin
            errors++; $display("FAIL pd_done got count=%0d at=%0d expected 1 at 10", done_cnt, done_at);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL pd_after got busy=%b rdy=%b err=%b expected 0/1/0", busy, req_ready, error);
        end
    endtask

    task automatic test_rate_change();
        int done_cnt, done_at;
        done_cnt = 0; done_at = -1;
        req_valid = 1'b1; req_type = 1'b1; req_rate = 4'h2;
        tick();
        req_valid = 1'b0;
        checks++;
        if (Rate !== 4'h2 || busy !== 1'b1) begin
            errors++; $display("FAIL rate_c1 got rate=%h busy=%b expected 2/1", Rate, busy);
        end
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (PclkChangeAck !== (c >= 5 && c <= 8)) begin
                errors++; $display("FAIL rate_ack c=%0d got %b expected %b", c, PclkChangeAck, (c >= 5 && c <= 8));
            end
            if (done) begin done_cnt++; done_at = c; end
            PclkChangeOk = (c == 4);
            // all-lane status while still waiting for PclkChangeOk must not count
            PhyStatus = (c == 3 || c == 8) ? '1 : '0;
            tick();
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 9) begin
            errors++; $display("FAIL rate_done got count=%0d at=%0d expected 1 at 9", done_cnt, done_at);
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt;
        done_cnt = 0;
        req_valid = 1'b1; req_type = 1'b0; req_powerdown = 4'h3;
        tick();
        req_valid = 1'b1; req_type = 1'b1; req_rate = 4'h5;
        tick();
        req_valid = 1'b0;
        PhyStatus = '1;
        tick();
        PhyStatus = '0;
        for (int c = 3; c <= 7; c++) begin
            if (done) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt !== 1 || Rate !== 4'h2 || PowerDown !== {16{4'h3}}) begin
            errors++; $display("FAIL busy_ignore got done=%0d rate=%h pd=%h expected 1/2/3333..", done_cnt, Rate, PowerDown);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || PclkChangeAck !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_idle got busy=%b rdy=%b ack=%b expected 0/1/0", busy, req_ready, PclkChangeAck);
        end
    endtask

    task automatic test_timeout();
        int err_cnt, err_at, done_cnt;
        err_cnt = 0; err_at = -1; done_cnt = 0;
        req_valid = 1'b1; req_type = 1'b0; req_powerdown = 4'h0;
        tick();
        req_valid = 1'b0;
        PhyStatus = 16'hFFF7;
        for (int c = 1; c <= 21; c++) begin
            if (error) begin err_cnt++; err_at = c; end
            if (done) done_cnt++;
            tick();
        end
        PhyStatus = '0;
        checks++;
        if (err_cnt !== 1 || err_at !== 21 || done_cnt !== 0) begin
            errors++; $display("FAIL timeout got err=%0d at=%0d done=%0d expected 1 at 21, 0 done", err_cnt, err_at, done_cnt);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || PowerDown !== 64'h0) begin
            errors++; $display("FAIL timeout_after got rdy=%b busy=%b err=%b pd=%h expected 1/0/0/0", req_ready, busy, error, PowerDown);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        req_valid = 1'b1; req_type = 1'b1; req_rate = 4'h3;
        tick();
        req_valid = 1'b0;
        PclkChangeOk = 1'b1;
        tick();
        PclkChangeOk = 1'b0;
        tick();
        checks++;
        if (PclkChangeAck !== 1'b1 || Rate !== 4'h3) begin
            errors++; $display("FAIL mid_setup got ack=%b rate=%h expected 1/3", PclkChangeAck, Rate);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({PclkChangeAck, busy, done, error, req_ready, phy_ready} !== 6'b0 || Rate !== 4'h0 || PowerDown !== PD_RST) begin
            errors++; $display("FAIL mid_reset got ctl=%b rate=%h pd=%h expected 000000/0/%h",
                {PclkChangeAck, busy, done, error, req_ready, phy_ready}, Rate, PowerDown, PD_RST);
        end
        tick();
        Reset = 1'b1;
        PhyStatus = '1;
        for (int c = 0; c < 6; c++) begin
            if (done || error) pulses++;
            if (c == 3) PhyStatus = '0;
            tick();
        end
        checks++;
        if (pulses !== 0 || phy_ready !== 1'b1 || req_ready !== 1'b1 || Rate !== 4'h0) begin
            errors++; $display("FAIL mid_recover got pulses=%0d phy_ready=%b rdy=%b rate=%h expected 0/1/1/0", pulses, phy_ready, req_ready, Rate);
        end
    endtask

    initial begin
        test_reset();
        test_same_value();
        test_power_change();
        test_rate_change();
        test_busy_ignore();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
